// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with ALU, data SRAM request,
// HI/LO registers and a 32-step restoring divider.
module ex_stage (
   input  logic         clk,
   input  logic         rst,
   input  logic [5:0]   stall,
   input  logic [158:0] id_to_ex_bus,
   output logic [75:0]  ex_to_mem_bus,
   output logic [75:0]  ex_to_id_bus,
   output logic         stall_en,
   output logic         stallreq_ex,
   output logic         data_sram_en,
   output logic [3:0]   data_sram_wen,
   output logic [31:0]  data_sram_addr,
   output logic [31:0]  data_sram_wdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } div_state_e;

   logic [158:0] ex_q;
   logic         load_new;

   assign load_new = ~stall[2] | ~stall[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q <= '0;
      end else if (stall[2] & ~stall[3]) begin
         ex_q <= '0;
      end else if (~stall[2]) begin
         ex_q <= id_to_ex_bus;
      end
   end

   logic [31:0] pc;
   logic [31:0] inst;
   logic [11:0] alu_op;
   logic [2:0]  sel_src1;
   logic [3:0]  sel_src2;
   logic        ram_en;
   logic [3:0]  ram_wen;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic        sel_rf_res;
   logic [31:0] rdata1;
   logic [31:0] rdata2;

   assign pc         = ex_q[158:127];
   assign inst       = ex_q[126:95];
   assign alu_op     = ex_q[94:83];
   assign sel_src1   = ex_q[82:80];
   assign sel_src2   = ex_q[79:76];
   assign ram_en     = ex_q[75];
   assign ram_wen    = ex_q[74:71];
   assign rf_we      = ex_q[70];
   assign rf_waddr   = ex_q[69:65];
   assign sel_rf_res = ex_q[64];
   assign rdata1     = ex_q[63:32];
   assign rdata2     = ex_q[31:0];

   logic special;
   logic is_mfhi;
   logic is_mflo;
   logic is_mthi;
   logic is_mtlo;
   logic is_div;
   logic is_divu;
   logic div_any;

   assign special = (inst[31:26] == 6'd0);
   assign is_mfhi = special & (inst[5:0] == 6'h10);
   assign is_mthi = special & (inst[5:0] == 6'h11);
   assign is_mflo = special & (inst[5:0] == 6'h12);
   assign is_mtlo = special & (inst[5:0] == 6'h13);
   assign is_div  = special & (inst[5:0] == 6'h1A);
   assign is_divu = special & (inst[5:0] == 6'h1B);
   assign div_any = is_div | is_divu;

   logic [31:0] src1;
   logic [31:0] src2;
   logic [31:0] alu_res;
   logic [4:0]  shamt;

   always_comb begin
      src1 = '0;
      unique case (1'b1)
         sel_src1[0]: src1 = rdata1;
         sel_src1[1]: src1 = pc;
         sel_src1[2]: src1 = {27'd0, inst[10:6]};
         default:     src1 = '0;
      endcase
   end

   always_comb begin
      src2 = '0;
      unique case (1'b1)
         sel_src2[0]: src2 = rdata2;
         sel_src2[1]: src2 = {{16{inst[15]}}, inst[15:0]};
         sel_src2[2]: src2 = 32'd8;
         sel_src2[3]: src2 = {16'd0, inst[15:0]};
         default:     src2 = '0;
      endcase
   end

   assign shamt = src1[4:0];

   always_comb begin
      alu_res = '0;
      unique case (1'b1)
         alu_op[11]: alu_res = src1 + src2;
         alu_op[10]: alu_res = src1 - src2;
         alu_op[9]:  alu_res = {31'd0, $signed(src1) < $signed(src2)};
         alu_op[8]:  alu_res = {31'd0, src1 < src2};
         alu_op[7]:  alu_res = src1 & src2;
         alu_op[6]:  alu_res = ~(src1 | src2);
         alu_op[5]:  alu_res = src1 | src2;
         alu_op[4]:  alu_res = src1 ^ src2;
         alu_op[3]:  alu_res = src2 << shamt;
         alu_op[2]:  alu_res = src2 >> shamt;
         alu_op[1]:  alu_res = $unsigned($signed(src2) >>> shamt);
         alu_op[0]:  alu_res = {src2[15:0], 16'h0};
         default:    alu_res = '0;
      endcase
   end

   div_state_e  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        done_q, done_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rs_q, rs_d;
   logic [31:0] rt_q, rt_d;
   logic        sgn_q, sgn_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [32:0] step;
   logic [32:0] diff;
   logic        fits;
   logic        neg_q;
   logic        neg_r;
   logic [31:0] abs1;
   logic [31:0] abs2;

   assign step  = {rem_q, quo_q[31]};
   assign diff  = step - {1'b0, dvs_q};
   assign fits  = (step >= {1'b0, dvs_q});
   assign neg_q = sgn_q & (rs_q[31] ^ rt_q[31]);
   assign neg_r = sgn_q & rs_q[31];
   assign abs1  = (is_div & rdata1[31]) ? -rdata1 : rdata1;
   assign abs2  = (is_div & rdata2[31]) ? -rdata2 : rdata2;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      sgn_d   = sgn_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (is_mthi) hi_d = rdata1;
      if (is_mtlo) lo_d = rdata1;
      case (state_q)
         S_IDLE: begin
            if (div_any & ~done_q) begin
               rs_d    = rdata1;
               rt_d    = rdata2;
               sgn_d   = is_div;
               quo_d   = abs1;
               dvs_d   = abs2;
               rem_d   = '0;
               cnt_d   = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            rem_d = fits ? diff[31:0] : step[31:0];
            quo_d = {quo_q[30:0], fits};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = S_DONE;
         end
         S_DONE: begin
            // A zero divisor leaves the raw dividend as remainder.
            if (rt_q == 32'd0) begin
               lo_d = 32'hFFFF_FFFF;
               hi_d = rs_q;
            end else begin
               lo_d = neg_q ? -quo_q : quo_q;
               hi_d = neg_r ? -rem_q : rem_q;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (load_new) done_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         sgn_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         sgn_q   <= sgn_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   logic [31:0] result;
   logic        out_we;
   logic [4:0]  out_wa;

   assign result = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);
   assign out_we = rf_we | is_mfhi | is_mflo;
   assign out_wa = (is_mfhi | is_mflo) ? inst[15:11] : rf_waddr;

   assign ex_to_mem_bus = {pc, ram_en, ram_wen, sel_rf_res,
                           out_we, out_wa, result};
   assign ex_to_id_bus  = ex_to_mem_bus;

   assign stall_en    = ram_en & sel_rf_res;
   assign stallreq_ex = (state_q == S_CALC) |
                        ((state_q == S_IDLE) & div_any & ~done_q);

   assign data_sram_en    = ram_en;
   assign data_sram_wen   = ram_wen;
   assign data_sram_addr  = alu_res;
   assign data_sram_wdata = rdata2;

   logic unused_bits;
   assign unused_bits = ^{stall[5:4], stall[1:0],
                          inst[25:16], diff[32]};

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode stage. It registers the decode-to-execute bus, computes the ALU result, and issues data SRAM requests. It also owns the HI/LO registers and runs a multi-cycle iterative divider for DIV/DIVU. It forwards its result to decode and raises a load-use hint and a divider stall request.

## Interface
- No parameters; all widths fixed.
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- stall  in  6  pipeline stall vector; bit i = Stop(1) holds stage i; bit 2 = decode, bit 3 = execute
- id_to_ex_bus  in  159  {pc[158:127], inst[126:95], alu_op[94:83], sel_src1[82:80], sel_src2[79:76], ram_en[75], ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0]}
- ex_to_mem_bus  out  76  {pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], result[31:0]}
- ex_to_id_bus  out  76  identical copy of ex_to_mem_bus, used for forwarding
- stall_en  out  1  load currently in EX: ram_en & sel_rf_res
- stallreq_ex  out  1  divider busy; stall controller holds stages 0–3
- data_sram_en  out  1  data SRAM enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  store data

## Operation
- EX register update, evaluated in priority order at each clk edge:
  - rst: clear the register to 0.
  - stall[2]=Stop and stall[3]=NoStop: load 0 (bubble).
  - stall[2]=NoStop: load id_to_ex_bus.
  - Otherwise: hold.
- src1 selection (one-hot):
  - [0] rdata1
  - [1] pc
  - [2] zero-extended inst[10:6]
  - none set: 0
- src2 selection (one-hot):
  - [0] rdata2
  - [1] sign-extended inst[15:0]
  - [2] 32'd8
  - [3] zero-extended inst[15:0]
- alu_op, one-hot, MSB first: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - add/sub wrap modulo 2^32; no overflow trap.
  - slt is signed, sltu unsigned; both produce 0 or 1.
  - Shifts shift src2 by src1[4:0]. sra replicates src2[31].
  - lui = {src2[15:0], 16'h0}.
  - All alu_op bits 0 gives result 0.
- Local decode from inst when opcode=0:
  - func 0x10 MFHI, 0x12 MFLO: result = HI / LO; rf_we forced 1; rf_waddr = inst[15:11].
  - func 0x11 MTHI, 0x13 MTLO: HI / LO <= rdata1 at the clock edge.
  - func 0x1A DIV (signed), 0x1B DIVU (unsigned): divider operands rs = rdata1, rt = rdata2.
- Data SRAM: en = ram_en, wen = ram_wen, addr = ALU result, wdata = rdata2.
- Divider FSM, states IDLE, CALC, DONE:
  - IDLE: if a div is in EX and div_done = 0: load |rs| and |rt| (raw values for DIVU), cnt <= 0, go to CALC.
  - CALC: one restoring shift-subtract step per cycle. After the step with cnt = 31, go to DONE.
  - DONE: apply signs (quotient negated if sign(rs) XOR sign(rt); remainder takes sign(rs)). Write LO <= quotient, HI <= remainder. Set div_done = 1 and go to IDLE.
  - div_done clears whenever the EX register loads new content (a bubble or a new instruction). This prevents re-issuing a div still held by an external stall.
  - Divide by zero: LO = 32'hFFFF_FFFF, HI = rs. The FSM still takes the full latency.
- rst mid-division: FSM to IDLE, cnt = 0, div_done = 0, HI = LO = 0, stallreq_ex = 0.

## Timing
- ALU, bus outputs, SRAM request, and stall_en are combinational from the EX register: valid in the cycle after the edge that latched the instruction.
- stallreq_ex:
  - High combinationally in the cycle a div occupies EX with state IDLE and div_done = 0.
  - Remains high through all 32 CALC cycles: 33 cycles high in total.
  - Low in DONE. The div leaves EX on the edge ending DONE, so it spends 34 cycles in EX.
- HI/LO write visibility:
  - HI/LO writes (DONE, MTHI, MTLO) take effect at the clock edge.
  - An MFHI/MFLO immediately following in program order reads the new value.
- Reset values:
  - All outputs 0; the EX register is all-zero, so every request and enable is deasserted.
  - State IDLE, HI = LO = 0.

## Test plan
- addiu $2,$0,5 followed by addu $3,$2,$2 -> ex_to_id_bus result 5 then 10; rf_waddr 2 then 3; rf_we 1.
- lw in EX -> stall_en = 1, data_sram_en = 1, wen = 0, addr = rdata1 + imm. A sw of 0xDEADBEEF -> wen = 4'hF, wdata = 0xDEADBEEF.
- DIV rs = -7, rt = 2 -> stallreq_ex high exactly 33 cycles; then MFLO gives 0xFFFFFFFD (-3) and MFHI gives 0xFFFFFFFF (-1).
- DIVU rs = 0xFFFFFFFF, rt = 0 -> LO = 0xFFFFFFFF, HI = 0xFFFFFFFF after the full latency.
- rst asserted in CALC cycle 10 -> next cycle stallreq_ex = 0, HI = LO = 0, all bus outputs 0; a DIV issued afterwards completes normally.
- stall[2]=Stop, stall[3]=NoStop -> EX bubble: rf_we = 0, data_sram_en = 0, result 0. MTHI 0x1234 then MFHI -> result 0x1234.
